// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if
//   Request/response bundle between the EX stage and the RV32M unit.
//
//   Handshake: start is the request valid and !busy is the ready. A request
//   transfers on a rising edge where start=1, busy=0, flush=0 and alucode is
//   an M op. The response is a single-cycle done pulse. result is valid in
//   that cycle and stays stable until the next transfer.
//
//   start    master->slave  op valid
//   alucode  master->slave  6-bit ALU code (MUL..REMU)
//   op1/op2  master->slave  rs1/rs2 values
//   flush    master->slave  abort in-flight op
//   busy     slave->master  op in flight (stall ID/EX)
//   done     slave->master  result valid this cycle
//   result   slave->master  rd value
interface muldiv_unit_if;
  logic        start;
  logic [5:0]  alucode;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  modport master (
    output start, alucode, op1, op2, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, alucode, op1, op2, flush,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit
//   Multi-cycle RV32M execute unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
//   Multiplies finish MUL_LAT cycles after accept. Divides use a restoring
//   radix-2 loop and finish 34 cycles after accept. A divide by zero or the
//   signed overflow case finishes 1 cycle after accept.
//
//   clk        in   clock, rising edge
//   reset      in   asynchronous, active-low reset
//   bus        slave modport of muldiv_unit_if (start/alucode/op1/op2/flush,
//              busy/done/result)
//   dbg_state  out  current FSM state, for observation only
module muldiv_unit #(
  parameter int MUL_LAT = 2  // legal 1..4
) (
  input  logic            clk,
  input  logic            reset,
  muldiv_unit_if.slave    bus,
  output logic [2:0]      dbg_state
);

  localparam logic [5:0] ALU_MUL    = 6'd20;
  localparam logic [5:0] ALU_MULH   = 6'd21;
  localparam logic [5:0] ALU_MULHSU = 6'd22;
  localparam logic [5:0] ALU_MULHU  = 6'd23;
  localparam logic [5:0] ALU_DIV    = 6'd24;
  localparam logic [5:0] ALU_DIVU   = 6'd25;
  localparam logic [5:0] ALU_REM    = 6'd26;
  localparam logic [5:0] ALU_REMU   = 6'd27;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_MUL   = 3'd1;
  localparam logic [2:0] S_DPREP = 3'd2;
  localparam logic [2:0] S_DITER = 3'd3;
  localparam logic [2:0] S_DFIN  = 3'd4;

  logic [2:0]  state;
  logic [4:0]  cnt;
  logic [5:0]  code_q;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] dvs;
  logic        neg_q;
  logic        neg_r;
  logic [31:0] result_q;

  // Decode of the incoming request
  logic is_mul_in;
  logic is_div_in;
  logic accept;
  logic div_zero_in;
  logic div_ovf_in;

  assign is_mul_in   = bus.alucode inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
  assign is_div_in   = bus.alucode inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  assign accept      = bus.start && (state == S_IDLE) && !bus.flush && (is_mul_in || is_div_in);
  assign div_zero_in = (bus.op2 == 32'h0);
  assign div_ovf_in  = (bus.alucode == ALU_DIV || bus.alucode == ALU_REM) &&
                       (bus.op1 == 32'h8000_0000) && (bus.op2 == 32'hFFFF_FFFF);

  // Multiply: extend both operands to 64 bits. The low 64 bits of the product
  // equal the 33x33 signed product, so one unsigned multiply covers all four ops.
  logic        mul_a_sgn;
  logic        mul_b_sgn;
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] prod;
  logic [31:0] mul_res;

  assign mul_a_sgn = (code_q == ALU_MULH) || (code_q == ALU_MULHSU);
  assign mul_b_sgn = (code_q == ALU_MULH);
  assign mul_a     = {{32{mul_a_sgn & op_a[31]}}, op_a};
  assign mul_b     = {{32{mul_b_sgn & op_b[31]}}, op_b};
  assign prod      = mul_a * mul_b;
  assign mul_res   = (code_q == ALU_MUL) ? prod[31:0] : prod[63:32];

  // Divide step: shift the next dividend bit into the partial remainder.
  // rem < dvs always holds, so shift < 2*dvs. A borrow (diff[32]) means
  // shift < dvs and the quotient bit is 0.
  logic        signed_div;
  logic [32:0] shift;
  logic [32:0] diff;
  logic        q_bit;
  logic [31:0] q_out;
  logic [31:0] r_out;
  logic [31:0] div_res;

  assign signed_div = (code_q == ALU_DIV) || (code_q == ALU_REM);
  assign shift      = {rem, quo[31]};
  assign diff       = shift - {1'b0, dvs};
  assign q_bit      = ~diff[32];
  assign q_out      = neg_q ? (32'h0 - quo) : quo;
  assign r_out      = neg_r ? (32'h0 - rem) : rem;
  assign div_res    = (code_q == ALU_REM || code_q == ALU_REMU) ? r_out : q_out;

  // Outputs. result shows the finished value during the done cycle and the
  // latched copy afterwards.
  logic        done_c;
  logic [31:0] final_val;

  assign done_c     = ((state == S_MUL) && (cnt == 5'd0)) || (state == S_DFIN);
  assign final_val  = (state == S_MUL) ? mul_res : div_res;
  assign bus.busy   = (state != S_IDLE);
  assign bus.done   = done_c;
  assign bus.result = done_c ? final_val : result_q;
  assign dbg_state  = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      cnt      <= 5'd0;
      code_q   <= 6'd0;
      op_a     <= 32'h0;
      op_b     <= 32'h0;
      quo      <= 32'h0;
      rem      <= 32'h0;
      dvs      <= 32'h0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_q <= 32'h0;
    end else begin
      // A done cycle delivers its result even if flush is raised in it.
      if (done_c) result_q <= final_val;

      if (bus.flush) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (accept) begin
              code_q <= bus.alucode;
              op_a   <= bus.op1;
              op_b   <= bus.op2;
              if (is_mul_in) begin
                cnt   <= 5'(MUL_LAT - 1);
                state <= S_MUL;
              end else if (div_zero_in) begin
                quo   <= 32'hFFFF_FFFF;
                rem   <= bus.op1;
                neg_q <= 1'b0;
                neg_r <= 1'b0;
                state <= S_DFIN;
              end else if (div_ovf_in) begin
                quo   <= 32'h8000_0000;
                rem   <= 32'h0;
                neg_q <= 1'b0;
                neg_r <= 1'b0;
                state <= S_DFIN;
              end else begin
                state <= S_DPREP;
              end
            end
          end
          S_MUL: begin
            if (cnt == 5'd0) state <= S_IDLE;
            else             cnt   <= cnt - 5'd1;
          end
          S_DPREP: begin
            // Work on magnitudes and remember the signs for the final fix-up.
            neg_q <= signed_div && (op_a[31] ^ op_b[31]);
            neg_r <= signed_div && op_a[31];
            quo   <= (signed_div && op_a[31]) ? (32'h0 - op_a) : op_a;
            dvs   <= (signed_div && op_b[31]) ? (32'h0 - op_b) : op_b;
            rem   <= 32'h0;
            cnt   <= 5'd31;
            state <= S_DITER;
          end
          S_DITER: begin
            rem <= q_bit ? diff[31:0] : shift[31:0];
            quo <= {quo[30:0], q_bit};
            if (cnt == 5'd0) state <= S_DFIN;
            else             cnt   <= cnt - 5'd1;
          end
          S_DFIN:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  localparam int MUL_LAT = 2;

  localparam logic [5:0] ALU_MUL    = 6'd20;
  localparam logic [5:0] ALU_MULH   = 6'd21;
  localparam logic [5:0] ALU_MULHSU = 6'd22;
  localparam logic [5:0] ALU_MULHU  = 6'd23;
  localparam logic [5:0] ALU_DIV    = 6'd24;
  localparam logic [5:0] ALU_DIVU   = 6'd25;
  localparam logic [5:0] ALU_REM    = 6'd26;
  localparam logic [5:0] ALU_REMU   = 6'd27;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  muldiv_unit_if bus();

  muldiv_unit #(.MUL_LAT(MUL_LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_result;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: plain 64-bit / integer arithmetic.
  function automatic logic [31:0] ref_result(input logic [5:0] code, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    int ia, ib;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'h0, a};
    ub = {32'h0, b};
    ia = a;
    ib = b;
    case (code)
      ALU_MUL:    begin p = sa * sb; return p[31:0];  end
      ALU_MULH:   begin p = sa * sb; return p[63:32]; end
      ALU_MULHSU: begin p = sa * ub; return p[63:32]; end
      ALU_MULHU:  begin p = ua * ub; return p[63:32]; end
      ALU_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      ALU_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return ia % ib;
      end
      ALU_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      ALU_REMU: return (b == 0) ? a : a % b;
      default:  return 32'h0;
    endcase
  endfunction

  function automatic int ref_latency(input logic [5:0] code, input logic [31:0] a,
                                     input logic [31:0] b);
    if (code inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU}) return MUL_LAT;
    if (b == 0) return 1;
    if ((code == ALU_DIV || code == ALU_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return 1;
    return 34;
  endfunction

  // ---------------- driver tasks ----------------
  // Entered and left just after a falling edge. With poke=1 start stays high
  // with a different M op for the whole flight, including the done cycle.
  task automatic run_op(input logic [5:0] code, input logic [31:0] a, input logic [31:0] b,
                        input bit poke, input string tag);
    int n;
    int exp_n;
    logic [31:0] exp_r;
    check({tag, " idle_busy"}, 32'(bus.busy), 32'd0);
    exp_q.push_back(ref_result(code, a, b));
    exp_n = ref_latency(code, a, b);
    bus.start   = 1'b1;
    bus.alucode = code;
    bus.op1     = a;
    bus.op2     = b;
    @(negedge clk);
    n = 1;
    if (poke) bus.alucode = ALU_MUL + 6'($urandom_range(0, 7));
    else      bus.start = 1'b0;
    bus.op1 = $urandom;
    bus.op2 = $urandom;
    while (!bus.done && n < 60) begin
      check({tag, " busy"}, 32'(bus.busy), 32'd1);
      @(negedge clk);
      n++;
    end
    check({tag, " done_seen"}, 32'(bus.done), 32'd1);
    check({tag, " latency"}, 32'(n), 32'(exp_n));
    check({tag, " busy_in_done"}, 32'(bus.busy), 32'd1);
    exp_r = exp_q.pop_front();
    check({tag, " result"}, bus.result, exp_r);
    last_result = exp_r;
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, " busy_after"}, 32'(bus.busy), 32'd0);
    check({tag, " done_after"}, 32'(bus.done), 32'd0);
    check({tag, " result_held"}, bus.result, exp_r);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [5:0]  c;
    logic [31:0] a, b, prev;

    reset       = 1'b0;
    bus.start   = 1'b0;
    bus.flush   = 1'b0;
    bus.alucode = 6'd0;
    bus.op1     = 32'h0;
    bus.op2     = 32'h0;
    last_result = 32'h0;

    #12;
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset result", bus.result, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Non-M code is never accepted
    bus.start   = 1'b1;
    bus.alucode = 6'd3;
    bus.op1     = 32'd9;
    bus.op2     = 32'd4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("nonm busy", 32'(bus.busy), 32'd0);
      check("nonm done", 32'(bus.done), 32'd0);
    end
    bus.start = 1'b0;

    run_op(ALU_MUL,    32'd7,          32'hFFFF_FFFD, 1'b0, "mul_neg");
    run_op(ALU_MULH,   32'h8000_0000,  32'h8000_0000, 1'b0, "mulh_min");
    run_op(ALU_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b0, "mulhu_max");
    run_op(ALU_MULHSU, 32'hFFFF_FFFF,  32'd2,         1'b1, "mulhsu");
    run_op(ALU_DIV,    32'hFFFF_FFF9,  32'd2,         1'b1, "div_neg");
    run_op(ALU_REM,    32'hFFFF_FFF9,  32'd2,         1'b0, "rem_neg");
    run_op(ALU_DIVU,   32'hFFFF_FFF9,  32'd2,         1'b0, "divu");
    run_op(ALU_DIVU,   32'h1234_5678,  32'd0,         1'b0, "divu_zero");
    run_op(ALU_REM,    32'd5,          32'd0,         1'b1, "rem_zero");
    run_op(ALU_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 1'b0, "div_ovf");
    run_op(ALU_REM,    32'h8000_0000,  32'hFFFF_FFFF, 1'b0, "rem_ovf");
    run_op(ALU_DIV,    32'hDEAD_BEEF,  32'd0,         1'b0, "div_zero");
    run_op(ALU_REMU,   32'hCAFE_F00D,  32'd0,         1'b0, "remu_zero");

    // Flush at cycle 10 of a divide, with a competing start in the same cycle
    prev        = last_result;
    bus.start   = 1'b1;
    bus.alucode = ALU_DIV;
    bus.op1     = 32'd1000;
    bus.op2     = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      check("flush busy", 32'(bus.busy), 32'd1);
      check("flush no_done", 32'(bus.done), 32'd0);
      if (n < 10) @(negedge clk);
    end
    bus.flush   = 1'b1;
    bus.start   = 1'b1;
    bus.alucode = ALU_MUL;
    @(negedge clk);
    bus.flush = 1'b0;
    bus.start = 1'b0;
    check("flush busy_drop", 32'(bus.busy), 32'd0);
    check("flush done", 32'(bus.done), 32'd0);
    check("flush result_kept", bus.result, prev);
    run_op(ALU_MUL, 32'd123, 32'd456, 1'b0, "mul_after_flush");
    for (int i = 0; i < 25; i++) begin
      check("flush no_late_done", 32'(bus.done), 32'd0);
      @(negedge clk);
    end

    // Randomized ops against the reference model
    for (int i = 0; i < 60; i++) begin
      c = ALU_MUL + 6'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'h0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: b = -32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op(c, a, b, bit'($urandom_range(0, 1)), "rand");
    end

    // Asynchronous reset at cycle 20 of a divide
    bus.start   = 1'b1;
    bus.alucode = ALU_DIVU;
    bus.op1     = $urandom;
    bus.op2     = 32'($urandom_range(1, 1000));
    @(negedge clk);
    bus.start = 1'b0;
    for (int n = 1; n < 20; n++) @(negedge clk);
    check("rst_mid busy_before", 32'(bus.busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("rst_mid busy", 32'(bus.busy), 32'd0);
    check("rst_mid done", 32'(bus.done), 32'd0);
    check("rst_mid result", bus.result, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_op(ALU_REM, 32'hFFFF_FF00, 32'd7, 1'b0, "rem_after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
